// File: rtl/time_ctrl_pkg.sv
// Shared encodings, field limits and digit-mask constants for the manual
// time-setting controller.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;

  localparam logic [7:0] MASK_HOUR = 8'b1100_0000;
  localparam logic [7:0] MASK_MIN  = 8'b0001_1000;
  localparam logic [7:0] MASK_SEC  = 8'b0000_0011;

  function automatic logic [5:0] clamp_field(input logic [5:0] val,
                                             input logic [5:0] max);
    return (val > max) ? max : val;
  endfunction

  // One wrapping increment or decrement inside 0..max.
  function automatic logic [5:0] step_field(input logic [5:0] val,
                                            input logic [5:0] max,
                                            input logic       up);
    if (up) return (val == max) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0) ? max : val - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_if.sv
// Bundle between board keys / time counter / digit scanner and the
// time-setting controller.
interface time_set_if;
  import time_ctrl_pkg::*;

  logic       key_mode;
  logic       key_up;
  logic       key_down;
  logic [5:0] cur_hour;
  logic [5:0] cur_minute;
  logic [5:0] cur_second;
  logic [5:0] set_hour;
  logic [5:0] set_minute;
  logic [5:0] set_second;
  logic       load;
  logic       run_en;
  mode_e      mode;
  logic [7:0] blink_mask;

  modport slave (
    input  key_mode, key_up, key_down, cur_hour, cur_minute, cur_second,
    output set_hour, set_minute, set_second, load, run_en, mode, blink_mask
  );

  modport master (
    output key_mode, key_up, key_down, cur_hour, cur_minute, cur_second,
    input  set_hour, set_minute, set_second, load, run_en, mode, blink_mask
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronizes one active-low raw key, debounces it and emits a one-cycle
// pulse on each accepted press (1->0); releases are silent.
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, which is what makes the two-stage synchronizer a chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode FSM, edit registers, blink phase and idle timeout that sequence
// manual time setting of the clock display.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int DB_CYCLES      = 1_000_000,
  parameter int BLINK_HALF     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input logic       clk,
  input logic       rst,
  time_set_if.slave bus
);

  localparam int               BLK_W     = $clog2(BLINK_HALF + 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_HALF - 1);
  localparam int               IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic w_mode_ev, w_up_ev, w_down_ev;
  logic w_step, w_any_ev, w_timeout, w_force;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_mode (
    .clk(clk), .rst(rst), .i_key_n(bus.key_mode), .o_press(w_mode_ev));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_up (
    .clk(clk), .rst(rst), .i_key_n(bus.key_up), .o_press(w_up_ev));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_down (
    .clk(clk), .rst(rst), .i_key_n(bus.key_down), .o_press(w_down_ev));

  mode_e             r_state, w_state_next;
  logic [5:0]        r_hour, r_min, r_sec;
  logic [5:0]        w_hour_next, w_min_next, w_sec_next;
  logic [5:0]        r_set_hour, r_set_min, r_set_sec;
  logic [5:0]        w_set_hour_next, w_set_min_next, w_set_sec_next;
  logic              r_load, w_load_next;
  logic              r_run_en, w_run_en_next;
  logic              r_phase, w_phase_next;
  logic [BLK_W-1:0]  r_blink_cnt, w_blink_cnt_next;
  logic [IDLE_W-1:0] r_idle, w_idle_next;
  logic [7:0]        w_mask;

  // Simultaneous up+down cancel; mode is checked first so it wins.
  assign w_step    = w_up_ev ^ w_down_ev;
  assign w_any_ev  = w_mode_ev | w_up_ev | w_down_ev;
  assign w_timeout = (r_idle == IDLE_LAST) && !w_any_ev;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_hour_next     = r_hour;
    w_min_next      = r_min;
    w_sec_next      = r_sec;
    w_set_hour_next = r_set_hour;
    w_set_min_next  = r_set_min;
    w_set_sec_next  = r_set_sec;
    w_load_next     = 1'b0;
    w_run_en_next   = r_run_en;
    w_force         = 1'b0;

    case (r_state)
      MODE_RUN: begin
        if (w_mode_ev) begin
          w_state_next  = MODE_SET_HOUR;
          w_hour_next   = clamp_field(bus.cur_hour,   HOUR_MAX);
          w_min_next    = clamp_field(bus.cur_minute, MIN_MAX);
          w_sec_next    = clamp_field(bus.cur_second, MIN_MAX);
          w_run_en_next = 1'b0;
          w_force       = 1'b1;
        end
      end
      MODE_SET_HOUR: begin
        if (w_mode_ev) begin
          w_state_next = MODE_SET_MIN;
          w_force      = 1'b1;
        end else if (w_timeout) begin
          w_state_next  = MODE_RUN;
          w_run_en_next = 1'b1;
        end else if (w_step) begin
          w_hour_next = step_field(r_hour, HOUR_MAX, w_up_ev);
          w_force     = 1'b1;
        end
      end
      MODE_SET_MIN: begin
        if (w_mode_ev) begin
          w_state_next = MODE_SET_SEC;
          w_force      = 1'b1;
        end else if (w_timeout) begin
          w_state_next  = MODE_RUN;
          w_run_en_next = 1'b1;
        end else if (w_step) begin
          w_min_next = step_field(r_min, MIN_MAX, w_up_ev);
          w_force    = 1'b1;
        end
      end
      MODE_SET_SEC: begin
        if (w_mode_ev) begin
          w_state_next    = MODE_RUN;
          w_set_hour_next = r_hour;
          w_set_min_next  = r_min;
          w_set_sec_next  = r_sec;
          w_load_next     = 1'b1;
          w_run_en_next   = 1'b1;
        end else if (w_timeout) begin
          w_state_next  = MODE_RUN;
          w_run_en_next = 1'b1;
        end else if (w_step) begin
          w_sec_next = step_field(r_sec, MIN_MAX, w_up_ev);
          w_force    = 1'b1;
        end
      end
      default: w_state_next = MODE_RUN;
    endcase

    w_idle_next = (r_state == MODE_RUN || w_any_ev || w_timeout)
                  ? '0 : r_idle + IDLE_W'(1);

    // Phase restarts visible on entering a field and after every edit.
    if (w_state_next == MODE_RUN || w_force) begin
      w_phase_next     = 1'b0;
      w_blink_cnt_next = '0;
    end else if (r_blink_cnt == BLK_LAST) begin
      w_phase_next     = ~r_phase;
      w_blink_cnt_next = '0;
    end else begin
      w_phase_next     = r_phase;
      w_blink_cnt_next = r_blink_cnt + BLK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MODE_RUN;
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
      r_set_hour  <= '0;
      r_set_min   <= '0;
      r_set_sec   <= '0;
      r_load      <= 1'b0;
      r_run_en    <= 1'b1;
      r_phase     <= 1'b0;
      r_blink_cnt <= '0;
      r_idle      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_hour      <= w_hour_next;
      r_min       <= w_min_next;
      r_sec       <= w_sec_next;
      r_set_hour  <= w_set_hour_next;
      r_set_min   <= w_set_min_next;
      r_set_sec   <= w_set_sec_next;
      r_load      <= w_load_next;
      r_run_en    <= w_run_en_next;
      r_phase     <= w_phase_next;
      r_blink_cnt <= w_blink_cnt_next;
      r_idle      <= w_idle_next;
    end
  end

  always_comb begin
    w_mask = 8'h00;
    case (r_state)
      MODE_SET_HOUR: w_mask = {8{r_phase}} & MASK_HOUR;
      MODE_SET_MIN:  w_mask = {8{r_phase}} & MASK_MIN;
      MODE_SET_SEC:  w_mask = {8{r_phase}} & MASK_SEC;
      default:       w_mask = 8'h00;
    endcase
  end

  assign bus.mode       = r_state;
  assign bus.load       = r_load;
  assign bus.run_en     = r_run_en;
  assign bus.set_hour   = r_set_hour;
  assign bus.set_minute = r_set_min;
  assign bus.set_second = r_set_sec;
  assign bus.blink_mask = w_mask;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Key-driven controller that sequences the clock-display datapath for manual time setting. It debounces three push-buttons and freezes the time counter while a field is edited. It steps through hour, minute and second edit modes, then loads the edited value back into the counter. It also drives a per-digit blink mask so the digit scanner flashes the field being edited. It sits between the board keys and the time counter / digit scanner, in front of the HC595 serial display chain.

## Interface
- DB_CYCLES, 1_000_000 — consecutive stable samples to accept a key level (20 ms at 50 MHz)
- BLINK_HALF, 12_500_000 — cycles per blink half-period (2 Hz)
- TIMEOUT_CYCLES, 500_000_000 — idle cycles in an edit mode before abandoning (10 s)
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock, synchronous, active-high
- key_mode  in  1  raw mode key, active-low, asynchronous to clk
- key_up  in  1  raw increment key, active-low
- key_down  in  1  raw decrement key, active-low
- cur_hour / cur_minute / cur_second  in  6 each  live time from the time counter
- set_hour / set_minute / set_second  out  6 each  value to load into the time counter
- load  out  1  one-cycle pulse: time counter loads set_*
- run_en  out  1  1 = time counter counts, 0 = frozen
- mode  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC
- blink_mask  out  8  1 blanks the digit; bit 7..0 = display digit 7..0

## Operation
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce counter: the accepted level changes only after DB_CYCLES consecutive samples differ from it.
  - A press event is a one-cycle pulse on an accepted 1→0 transition.
  - Releases produce no event. There is no auto-repeat.
- FSM:
  - RUN + mode press → SET_HOUR. On this transition cur_* is captured into the edit registers and run_en becomes 0.
  - SET_HOUR + mode press → SET_MIN.
  - SET_MIN + mode press → SET_SEC.
  - SET_SEC + mode press → RUN. load pulses, set_* = edit registers, run_en = 1.
- Edit arithmetic, active field only:
  - up: hour 23→0, minute/second 59→0, otherwise +1.
  - down: 0→23 for hour, 0→59 for minute/second, otherwise −1.
  - Captured values above the legal maximum are clamped to the maximum on capture.
- Simultaneous events:
  - up and down in the same cycle: both ignored.
  - mode together with up or down: mode wins, the others are ignored.
- Timeout:
  - The idle counter clears on any press event.
  - In any SET state, reaching TIMEOUT_CYCLES → RUN with run_en = 1 and no load; edits are discarded.
  - The counter is held at 0 in RUN.
- Blink:
  - Phase flop toggles every BLINK_HALF cycles.
  - Phase is forced to 0 (digits visible) on entry to any SET state and on every accepted up/down event.
  - Mask mapping: SET_HOUR → bits 7:6, SET_MIN → bits 4:3, SET_SEC → bits 1:0, each = phase.
  - Bits 5 and 2 (separators) are always 0. In RUN the whole mask is 0.
- set_* hold their last loaded value between loads.

## Timing
- Reset values:
  - mode = 0, run_en = 1, load = 0, set_* = 0, blink_mask = 0.
  - Edit registers = 0, blink phase = 0, idle counter = 0.
  - Accepted key levels = 1 (released).
- A key held low through reset yields one press event after the synchronizer delay plus DB_CYCLES.
- Latency from raw key edge to press pulse: 2 synchronizer cycles + DB_CYCLES + 1.
- Press pulse at cycle t → mode, edit registers, run_en and blink_mask update at t+1.
- load is high for exactly cycle t+1. set_* are valid in that cycle and stay stable afterwards.
- Reset asserted mid-edit: next cycle is RUN with no load.

## Structure
- Package time_ctrl_pkg holds:
  - Mode encodings MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN, MODE_SET_SEC.
  - HOUR_MAX = 23, MIN_MAX = 59.
  - Digit mask constants MASK_HOUR = 8'b1100_0000, MASK_MIN = 8'b0001_1000, MASK_SEC = 8'b0000_0011.
- One sub-module, key_debounce (synchronizer + debounce counter + press pulse), instantiated three times.
- The FSM, edit registers, blink and timeout logic live in time_set_ctrl.

## Test plan
Bench parameters: DB_CYCLES = 4, BLINK_HALF = 8, TIMEOUT_CYCLES = 64.
- Full set flow:
  - Stimulus: cur = 12:34:56. Presses: mode; up ×3; mode; down ×40; mode; up; mode.
  - Required: load pulses once with set = 15:54:57 and run_en = 1. Mode sequence is 0,1,2,3,0.
- Wrap:
  - In SET_HOUR from 23, up → 0; down → 23.
  - In SET_MIN from 0, down → 59.
- Bounce:
  - Stimulus: key_up toggles every 2 cycles for 20 cycles, then held low.
  - Required: exactly one increment. A 3-cycle low glitch produces none.
- Simultaneous events:
  - up + down in the same cycle: edit value unchanged.
  - mode + up in the same cycle: mode advances, value unchanged.
- Timeout:
  - Stimulus: enter SET_MIN, change the value, stay idle for 64 cycles.
  - Required: mode = 0, run_en = 1, no load, set_* unchanged.
- Blink and reset:
  - In SET_SEC, blink_mask alternates 0x03/0x00 every 8 cycles. An up press forces 0x00.
  - Synchronous rst mid-edit: all outputs return to their reset values the next cycle.
